// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// transaction kinds and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, DONE1} state_t;
    typedef enum logic {DATA, FETCH} kind_t;

    // Size 3 is an alias for word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic shared by the store path (enables, lane replication) and
// the load path (lane extraction with sign/zero extension).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {lo, 3'b000};
        be        = 4'hF;
        wdata_rep = wdata;
        ldata     = shifted;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << lo;
                wdata_rep = {4{wdata[7:0]}};
                ldata     = {{24{sgn & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << lo;
                wdata_rep = {2{wdata[15:0]}};
                ldata     = {{16{sgn & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit owning the shared instruction/data RAM: arbitrates program
// load, data access and instruction fetch, one transaction at a time.
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int               ADDR_W  = 9,
    parameter int               DATA_W  = 32,
    parameter int               REG_W   = 4,
    parameter int               RAM_LAT = 1,
    parameter logic [REG_W-1:0] NO_WB   = '1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              working,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_wr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] instr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W+1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [REG_W-1:0]  mem_dst,
    output logic              mem_ready,
    output logic              mem_done,
    output logic              mem_misalign,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_dst,
    output logic              stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wen,
    output logic [3:0]        ram_be,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ren,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    state_t            state;
    kind_t             kind;
    logic [2:0]        cnt;
    logic              mis_q, sgn_q;
    logic [1:0]        lo_q, size_q;
    logic [REG_W-1:0]  dst_q;
    logic [DATA_W-1:0] instr_q, wb_data_q;

    logic              idle, mis_now, acc_load, acc_store, resp;
    logic [3:0]        be_a;
    logic [DATA_W-1:0] wrep, ldata;

    assign idle      = (state == IDLE);
    assign ld_ready  = reset_n & idle & ~working;
    assign mem_ready = reset_n & idle & working & mem_req;
    assign if_ready  = reset_n & idle & working & if_req & ~mem_req;
    assign mis_now   = misaligned(mem_size, mem_addr[1:0]);
    assign acc_load  = mem_ready & ~mem_we & ~mis_now;
    assign acc_store = mem_ready & mem_we & ~mis_now;

    // One lane unit: live request in the accept cycle, latched load context later.
    lsu_align u_align (
        .size      (idle ? mem_size : size_q),
        .lo        (idle ? mem_addr[1:0] : lo_q),
        .sgn       (sgn_q),
        .wdata     (mem_wdata),
        .rdata     (ram_rdata),
        .be        (be_a),
        .wdata_rep (wrep),
        .ldata     (ldata)
    );

    always_comb begin
        ram_addr  = '0;
        ram_wen   = 1'b0;
        ram_be    = '0;
        ram_wdata = '0;
        ram_ren   = 1'b0;
        if (ld_ready & ld_wr) begin
            ram_addr  = ld_addr;
            ram_wen   = 1'b1;
            ram_be    = 4'hF;
            ram_wdata = ld_wdata;
        end else if (acc_store) begin
            ram_addr  = mem_addr[ADDR_W+1:2];
            ram_wen   = 1'b1;
            ram_be    = be_a;
            ram_wdata = wrep;
        end else if (acc_load) begin
            ram_addr = mem_addr[ADDR_W+1:2];
            ram_ren  = 1'b1;
        end else if (if_ready) begin
            ram_addr = if_addr;
            ram_ren  = 1'b1;
        end
    end

    assign resp         = (state == RD_WAIT) & (cnt == LAT);
    assign if_valid     = resp & (kind == FETCH);
    assign wb_valid     = resp & (kind == DATA);
    assign mem_done     = wb_valid | (state == DONE1);
    assign mem_misalign = (state == DONE1) & mis_q;
    assign wb_dst       = wb_valid ? dst_q : NO_WB;
    // Response data is visible in the pulse cycle and held afterwards.
    assign wb_data      = wb_valid ? ldata : wb_data_q;
    assign instr        = if_valid ? ram_rdata : instr_q;
    assign stall        = ~idle | (working & if_req & mem_req);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            kind      <= DATA;
            cnt       <= '0;
            mis_q     <= 1'b0;
            sgn_q     <= 1'b0;
            lo_q      <= '0;
            size_q    <= '0;
            dst_q     <= NO_WB;
            instr_q   <= '0;
            wb_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    mis_q <= 1'b0;
                    if (acc_load | if_ready) begin
                        state  <= RD_WAIT;
                        cnt    <= 3'd1;
                        kind   <= acc_load ? DATA : FETCH;
                        lo_q   <= mem_addr[1:0];
                        size_q <= mem_size;
                        sgn_q  <= mem_signed;
                        dst_q  <= mem_dst;
                    end else if (mem_ready) begin
                        state <= DONE1;
                        kind  <= DATA;
                        mis_q <= mis_now;
                    end
                end
                RD_WAIT: begin
                    if (cnt == LAT) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE1:   state <= IDLE;
                default: state <= IDLE;
            endcase
            if (if_valid) instr_q <= ram_rdata;
            if (wb_valid) wb_data_q <= ldata;
        end
    end

endmodule

// File: tb/tb_lsu_pipe.sv
// Bench for lsu_pipe: two instances (RAM_LAT 1 and 3) each with a RAM model,
// directed cases plus random traffic checked against a transaction-level model.
module tb_lsu_pipe;

    localparam int         ADDR_W = 9;
    localparam int         REG_W  = 4;
    localparam logic [3:0] NO_WB  = 4'hF;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int sel = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic              working, ld_wr, if_req, mem_req, mem_we, mem_signed;
    logic [ADDR_W-1:0] ld_addr, if_addr;
    logic [31:0]       ld_wdata, mem_wdata;
    logic [1:0]        mem_size;
    logic [ADDR_W+1:0] mem_addr;
    logic [3:0]        mem_dst;

    logic              ld_ready_a[2], if_ready_a[2], if_valid_a[2], mem_ready_a[2];
    logic              mem_done_a[2], mis_a[2], wb_valid_a[2], stall_a[2];
    logic              ram_wen_a[2], ram_ren_a[2];
    logic [31:0]       instr_a[2], wb_data_a[2], ram_wdata_a[2], ram_rdata_a[2];
    logic [3:0]        wb_dst_a[2], ram_be_a[2];
    logic [ADDR_W-1:0] ram_addr_a[2];

    logic [31:0] model[2][512];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic on;
        logic [31:0] ram[512];
        logic [31:0] rd_pipe[LAT];
        assign on = (sel == g);

        lsu_pipe #(.ADDR_W(ADDR_W), .DATA_W(32), .REG_W(REG_W), .RAM_LAT(LAT), .NO_WB(NO_WB)) u_dut (
            .clock(clock), .reset_n(reset_n), .working(on ? working : 1'b1),
            .ld_addr(ld_addr), .ld_wr(on & ld_wr), .ld_wdata(ld_wdata), .ld_ready(ld_ready_a[g]),
            .if_req(on & if_req), .if_addr(if_addr), .if_ready(if_ready_a[g]),
            .if_valid(if_valid_a[g]), .instr(instr_a[g]),
            .mem_req(on & mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
            .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dst(mem_dst),
            .mem_ready(mem_ready_a[g]), .mem_done(mem_done_a[g]), .mem_misalign(mis_a[g]),
            .wb_valid(wb_valid_a[g]), .wb_data(wb_data_a[g]), .wb_dst(wb_dst_a[g]),
            .stall(stall_a[g]), .ram_addr(ram_addr_a[g]), .ram_wen(ram_wen_a[g]),
            .ram_be(ram_be_a[g]), .ram_wdata(ram_wdata_a[g]), .ram_ren(ram_ren_a[g]),
            .ram_rdata(ram_rdata_a[g])
        );

        always @(posedge clock) begin
            if (ram_wen_a[g])
                for (int b = 0; b < 4; b++)
                    if (ram_be_a[g][b]) ram[ram_addr_a[g]][8*b +: 8] <= ram_wdata_a[g][8*b +: 8];
            rd_pipe[0] <= ram_ren_a[g] ? ram[ram_addr_a[g]] : 32'h0;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign ram_rdata_a[g] = rd_pipe[LAT-1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input int n, input logic sgn, input int lo);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        logic [31:0] v = (w >> (8 * lo)) & mask;
        if (sgn && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ld_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        working = 1'b0;
        @(negedge clock);
        ld_wr = 1'b1; ld_addr = a; ld_wdata = d; if_req = 1'b1;
        #1;
        chk("ld_ready", 32'(ld_ready_a[sel]), 32'd1);
        chk("ld_if_ready", 32'(if_ready_a[sel]), 32'd0);
        chk("ld_ram_wen", 32'(ram_wen_a[sel]), 32'd1);
        chk("ld_ram_addr", 32'(ram_addr_a[sel]), 32'(a));
        chk("ld_ram_be", 32'(ram_be_a[sel]), 32'hF);
        chk("ld_ram_wdata", ram_wdata_a[sel], d);
        model[sel][a] = d;
        @(negedge clock);
        ld_wr = 1'b0; if_req = 1'b0; working = 1'b1;
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] a);
        int lat = (sel == 0) ? 1 : 3;
        int k = 1;
        @(negedge clock);
        if_req = 1'b1; if_addr = a;
        #1;
        chk("if_ready", 32'(if_ready_a[sel]), 32'd1);
        chk("if_ram_ren", 32'(ram_ren_a[sel]), 32'd1);
        chk("if_ram_addr", 32'(ram_addr_a[sel]), 32'(a));
        @(negedge clock);
        if_req = 1'b0;
        while (!if_valid_a[sel] && k < 8) begin @(negedge clock); k++; end
        chk("if_latency", 32'(k), 32'(lat));
        chk("instr", instr_a[sel], model[sel][a]);
    endtask

    task automatic do_mem(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [ADDR_W+1:0] a, input logic [31:0] wd, input logic [3:0] dst);
        int lat = (sel == 0) ? 1 : 3;
        int n = nbytes(sz);
        int lo = int'(a[1:0]);
        logic mis = (lo % n) != 0;
        logic [3:0] be = 4'(((1 << n) - 1) << lo);
        logic [31:0] rep = (n == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                           (n == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        logic [31:0] ld_exp = exp_load(model[sel][a[ADDR_W+1:2]], n, sgn, lo);
        logic rd = !mis && !we;
        int k = 1;
        @(negedge clock);
        mem_req = 1'b1; mem_we = we; mem_size = sz; mem_signed = sgn;
        mem_addr = a; mem_wdata = wd; mem_dst = dst;
        #1;
        chk("mem_ready", 32'(mem_ready_a[sel]), 32'd1);
        chk("mem_ram_ren", 32'(ram_ren_a[sel]), 32'(rd));
        chk("mem_ram_wen", 32'(ram_wen_a[sel]), 32'(!mis && we));
        if (!mis) chk("mem_ram_addr", 32'(ram_addr_a[sel]), 32'(a[ADDR_W+1:2]));
        if (!mis && we) begin
            chk("st_ram_be", 32'(ram_be_a[sel]), 32'(be));
            chk("st_ram_wdata", ram_wdata_a[sel], rep);
            for (int b = 0; b < 4; b++)
                if (be[b]) model[sel][a[ADDR_W+1:2]][8*b +: 8] = rep[8*b +: 8];
        end
        @(negedge clock);
        mem_req = 1'b0;
        chk("busy_stall", 32'(stall_a[sel]), 32'd1);
        while (!mem_done_a[sel] && k < 8) begin @(negedge clock); k++; end
        chk("done_latency", 32'(k), rd ? 32'(lat) : 32'd1);
        chk("misalign", 32'(mis_a[sel]), 32'(mis));
        chk("wb_valid", 32'(wb_valid_a[sel]), 32'(rd));
        chk("wb_dst", 32'(wb_dst_a[sel]), rd ? 32'(dst) : 32'(NO_WB));
        if (rd) chk("wb_data", wb_data_a[sel], ld_exp);
    endtask

    initial begin
        int k;
        working = 1'b0; ld_wr = 1'b1; if_req = 1'b1; mem_req = 1'b1;
        mem_we = 1'b0; mem_signed = 1'b0; ld_addr = '0; if_addr = '0;
        ld_wdata = '0; mem_wdata = '0; mem_size = 2'd2; mem_addr = '0; mem_dst = '0;
        repeat (2) @(negedge clock);
        chk("rst_ld_ready", 32'(ld_ready_a[0]), 32'd0);
        chk("rst_if_ready", 32'(if_ready_a[0]), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready_a[0]), 32'd0);
        chk("rst_ram_wen", 32'(ram_wen_a[0]), 32'd0);
        chk("rst_wb_dst", 32'(wb_dst_a[0]), 32'(NO_WB));
        chk("rst_instr", instr_a[0], 32'd0);
        chk("rst_wb_data", wb_data_a[0], 32'd0);
        chk("rst_pulses", {29'd0, wb_valid_a[0], if_valid_a[0], mem_done_a[0]}, 32'd0);
        ld_wr = 1'b0; if_req = 1'b0; mem_req = 1'b0;
        reset_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < 16; w++) ld_write(9'(w), $urandom);
        end

        // LAT=1 directed cases
        sel = 0;
        ld_write(9'd5, 32'hDEAD_BEEF);
        do_fetch(9'd5);
        do_mem(1'b1, 2'd1, 1'b0, 11'h16, 32'h0000_ABCD, 4'd3);
        chk("instr_held", instr_a[0], 32'hDEAD_BEEF);
        ld_write(9'd5, 32'h12C0_FF34);
        do_mem(1'b0, 2'd0, 1'b1, 11'h16, 32'd0, 4'd7);
        do_mem(1'b0, 2'd0, 1'b0, 11'h16, 32'd0, 4'd7);
        do_mem(1'b0, 2'd0, 1'b1, 11'h15, 32'd0, 4'd2);
        do_mem(1'b0, 2'd2, 1'b0, 11'h13, 32'd0, 4'd2);
        @(negedge clock);
        ld_wr = 1'b1; ld_addr = 9'd5; ld_wdata = 32'h0;
        #1;
        chk("ldwr_blocked_ready", 32'(ld_ready_a[0]), 32'd0);
        chk("ldwr_blocked_wen", 32'(ram_wen_a[0]), 32'd0);
        @(negedge clock);
        ld_wr = 1'b0;
        do_fetch(9'd5);

        // LAT=3: data beats fetch, fetch taken on the next idle cycle
        sel = 1;
        @(negedge clock);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_signed = 1'b0;
        mem_addr = 11'h14; mem_dst = 4'd9; if_req = 1'b1; if_addr = 9'd3;
        #1;
        chk("arb_mem_ready", 32'(mem_ready_a[1]), 32'd1);
        chk("arb_if_ready", 32'(if_ready_a[1]), 32'd0);
        chk("arb_stall", 32'(stall_a[1]), 32'd1);
        @(negedge clock);
        mem_req = 1'b0;
        k = 1;
        while (!wb_valid_a[1] && k < 8) begin @(negedge clock); k++; end
        chk("arb_wb_latency", 32'(k), 32'd3);
        chk("arb_wb_data", wb_data_a[1], model[1][5]);
        chk("arb_wb_dst", 32'(wb_dst_a[1]), 32'd9);
        @(negedge clock);
        chk("arb_if_ready_next", 32'(if_ready_a[1]), 32'd1);
        @(negedge clock);
        if_req = 1'b0;
        k = 1;
        while (!if_valid_a[1] && k < 8) begin @(negedge clock); k++; end
        chk("arb_if_latency", 32'(k), 32'd3);
        chk("arb_instr", instr_a[1], model[1][3]);

        // reset in the middle of a read wait
        @(negedge clock);
        mem_req = 1'b1; mem_addr = 11'h08; mem_dst = 4'd4;
        @(negedge clock);
        mem_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pulses", {29'd0, wb_valid_a[1], if_valid_a[1], mem_done_a[1]}, 32'd0);
        chk("mid_rst_wb_dst", 32'(wb_dst_a[1]), 32'(NO_WB));
        chk("mid_rst_stall", 32'(stall_a[1]), 32'd0);
        chk("mid_rst_instr", instr_a[1], 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        k = 0;
        repeat (5) begin @(negedge clock); if (wb_valid_a[1] || mem_done_a[1]) k++; end
        chk("mid_rst_no_resp", 32'(k), 32'd0);

        for (int s = 0; s < 2; s++) begin
            sel = s;
            repeat (60) begin
                if ($urandom_range(0, 2) == 0) do_fetch(9'($urandom_range(0, 15)));
                else do_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            11'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 14)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
